// File: rtl/vram_arbiter.sv
// Arbitrates one sync VRAM between display scan-out reads (2-cycle latency) and CPU writes.
// CPU writes queue in a small FIFO (cpu_wready low when full) and drain one per blanking cycle.
module vram_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             isHorizontalActive,
  input  logic                             isVerticalActive,
  input  logic [ADDR_W-1:0]                disp_addr,
  output logic [DATA_W-1:0]                disp_rdata,
  output logic                             disp_rvalid,
  input  logic                             cpu_wvalid,
  input  logic [ADDR_W-1:0]                cpu_waddr,
  input  logic [DATA_W-1:0]                cpu_wdata,
  output logic                             cpu_wready,
  output logic [ADDR_W-1:0]                ram_addr,
  output logic [DATA_W-1:0]                ram_wdata,
  output logic                             ram_we,
  input  logic [DATA_W-1:0]                ram_rdata,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DISP  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]        state;
  logic              active;
  logic              push;
  logic              pop;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              rd_tag0;
  logic              rd_tag1;
  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

  assign active     = isHorizontalActive & isVerticalActive;
  assign cpu_wready = !rst && (fifo_level != LW'(FIFO_DEPTH));
  assign push       = cpu_wvalid & cpu_wready;
  // Live active gates the pop so a write never lands on a cycle the display owns.
  assign pop        = (state == WRITE) && !active && (fifo_level != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= cpu_waddr;
      data_mem[wr_ptr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_we      <= 1'b0;
      rd_tag0     <= 1'b0;
      rd_tag1     <= 1'b0;
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
    end else begin
      if (active)
        state <= DISP;
      else if (fifo_level != '0)
        state <= WRITE;
      else
        state <= IDLE;

      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        fifo_level <= fifo_level + LW'(1);
      else if (!push && pop)
        fifo_level <= fifo_level - LW'(1);

      ram_we <= pop;
      if (active) begin
        ram_addr <= disp_addr;
      end else if (pop) begin
        ram_addr  <= addr_mem[rd_ptr];
        ram_wdata <= data_mem[rd_ptr];
      end

      // Tag follows the read through the RAM's one-cycle access.
      rd_tag0     <= active;
      rd_tag1     <= rd_tag0;
      disp_rvalid <= rd_tag1;
      if (rd_tag1)
        disp_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed scenarios followed by random traffic, all checked against a transaction-level model.
module tb_vram_arbiter;

  typedef struct packed {
    logic [14:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        h_act, v_act;
  logic [14:0] disp_addr;
  logic [7:0]  disp_rdata;
  logic        disp_rvalid;
  logic        cpu_wvalid;
  logic [14:0] cpu_waddr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wready;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic [2:0]  fifo_level;

  always #5 clk = ~clk;

  // VRAM model: read data is the low address byte, one cycle after the address.
  always_ff @(posedge clk) ram_rdata <= ram_addr[7:0];

  vram_arbiter dut (
    .clk(clk), .rst(rst),
    .isHorizontalActive(h_act), .isVerticalActive(v_act),
    .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .cpu_wvalid(cpu_wvalid), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_wready(cpu_wready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .fifo_level(fifo_level)
  );

  wr_t tx_q[$];   // writes the CPU still wants to issue
  wr_t exp_q[$];  // writes accepted but not yet seen at the RAM
  int  n_assert = 0;
  int  n_fail   = 0;
  int  lvl      = 0;
  bit  blank_prev_nonempty = 0;
  bit  rv0 = 0, rv1 = 0;
  logic [7:0]  rd0 = '0, rd1 = '0;
  logic [14:0] e_addr = '0;
  logic [7:0]  e_wdata = '0, e_rdata = '0;
  bit  e_we = 0, e_rv = 0;
  int  n_we = 0, n_rv = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_tx(input logic [14:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    tx_q.push_back(w);
  endtask

  task automatic cycle(input bit r, input bit h, input bit v, input logic [14:0] da);
    bit act, push, pop;
    @(negedge clk);
    rst = r; h_act = h; v_act = v; disp_addr = da;
    cpu_wvalid = (tx_q.size() > 0);
    if (cpu_wvalid) begin
      cpu_waddr = tx_q[0].a;
      cpu_wdata = tx_q[0].d;
    end else begin
      cpu_waddr = 15'($urandom);
      cpu_wdata = 8'($urandom);
    end
    #1;
    chk("wready_pre", 32'(cpu_wready), 32'(!r && lvl != 4));
    @(posedge clk);
    act = h & v;
    if (r) begin
      lvl = 0; exp_q.delete(); blank_prev_nonempty = 0;
      rv0 = 0; rv1 = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_rv = 0; e_rdata = '0;
    end else begin
      push = cpu_wvalid && (lvl != 4);
      // A write goes out only on the second consecutive blanking edge with data queued.
      pop  = blank_prev_nonempty && !act && lvl > 0;
      blank_prev_nonempty = !act && lvl > 0;
      e_we = pop;
      if (act) begin
        e_addr = da;
      end else if (pop) begin
        e_addr  = exp_q[0].a;
        e_wdata = exp_q[0].d;
        void'(exp_q.pop_front());
      end
      e_rv = rv1;
      if (rv1) e_rdata = rd1;
      rv1 = rv0; rd1 = rd0;
      rv0 = act; rd0 = da[7:0];
      if (push) begin
        exp_q.push_back(tx_q[0]);
        void'(tx_q.pop_front());
      end
      lvl = lvl + int'(push) - int'(pop);
    end
    #1;
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    if (e_we || r) chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
    chk("disp_rvalid", 32'(disp_rvalid), 32'(e_rv));
    chk("disp_rdata", 32'(disp_rdata), 32'(e_rdata));
    chk("fifo_level", 32'(fifo_level), 32'(lvl));
    chk("wready_post", 32'(cpu_wready), 32'(!r && lvl != 4));
    if (ram_we) n_we++;
    if (disp_rvalid) n_rv++;
  endtask

  initial begin
    int base_we, base_rv;
    bit h, v;
    rst = 1'b1; h_act = 1'b0; v_act = 1'b0; disp_addr = '0;
    cpu_wvalid = 1'b0; cpu_waddr = '0; cpu_wdata = '0;

    // Reset with a write request held: nothing accepted or written until release.
    add_tx(15'h7fff, 8'h55);
    repeat (3) cycle(1, 0, 0, 15'h0);
    chk("reset_no_we", 32'(n_we), 32'd0);
    repeat (6) cycle(0, 0, 0, 15'h0);
    chk("post_reset_write", 32'(n_we), 32'd1);

    // Display reads 0x10..0x13, two-cycle latency.
    base_rv = n_rv; base_we = n_we;
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 15'h10 + 15'(i));
    repeat (3) cycle(0, 0, 0, 15'h0);
    chk("disp_count", 32'(n_rv - base_rv), 32'd4);
    chk("disp_no_we", 32'(n_we - base_we), 32'd0);

    // Single blanking write.
    base_we = n_we;
    add_tx(15'h0100, 8'hAA);
    repeat (5) cycle(0, 0, 0, 15'h0);
    chk("single_write", 32'(n_we - base_we), 32'd1);

    // Six writes during active: stall at full, then drain in order.
    base_we = n_we;
    for (int i = 0; i < 6; i++) add_tx(15'h0200 + 15'(i), 8'hB0 + 8'(i));
    repeat (8) cycle(0, 1, 1, 15'($urandom));
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_wready", 32'(cpu_wready), 32'd0);
    chk("full_no_we", 32'(n_we - base_we), 32'd0);
    repeat (12) cycle(0, 0, 0, 15'h0);
    chk("drain_all", 32'(n_we - base_we), 32'd6);

    // Three queued, active returns one cycle into the drain.
    base_we = n_we;
    for (int i = 0; i < 3; i++) add_tx(15'h0300 + 15'(i), 8'hC0 + 8'(i));
    repeat (5) cycle(0, 1, 1, 15'($urandom));
    repeat (2) cycle(0, 0, 0, 15'h0);
    repeat (4) cycle(0, 1, 1, 15'($urandom));
    chk("boundary_one_write", 32'(n_we - base_we), 32'd1);
    repeat (6) cycle(0, 0, 0, 15'h0);
    chk("boundary_rest", 32'(n_we - base_we), 32'd3);

    // Reset in the middle of a drain.
    for (int i = 0; i < 3; i++) add_tx(15'h0400 + 15'(i), 8'hD0 + 8'(i));
    repeat (5) cycle(0, 1, 1, 15'($urandom));
    repeat (2) cycle(0, 0, 0, 15'h0);
    cycle(1, 0, 0, 15'h0);
    base_we = n_we;
    repeat (4) cycle(0, 0, 0, 15'h0);
    chk("reset_drain_no_we", 32'(n_we - base_we), 32'd0);
    chk("reset_drain_level", 32'(fifo_level), 32'd0);
    add_tx(15'h0100, 8'hAA);
    repeat (5) cycle(0, 0, 0, 15'h0);
    chk("after_reset_write", 32'(n_we - base_we), 32'd1);

    // Random traffic.
    h = 0; v = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) h = !h;
      if ($urandom_range(63) == 0) v = !v;
      if (tx_q.size() < 3 && $urandom_range(2) == 0) add_tx(15'($urandom), 8'($urandom));
      cycle(($urandom_range(499) == 0), h, v, 15'($urandom));
    end
    repeat (20) cycle(0, 0, 0, 15'h0);
    chk("final_tx_empty", 32'(tx_q.size()), 32'd0);
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
